// File: rtl/decode_scoreboard.sv
// Single-entry decode stage with a per-register busy scoreboard for RAW/WAW hazard detection.
// Optional feature: define ID_SB_FWD_EN to let a source whose counter reads 1 issue via EX forwarding.
module decode_scoreboard #(
    parameter int LD_LAT  = 2,
    parameter int MUL_LAT = 3,
    parameter int ALU_LAT = 1,
    parameter int CNT_W   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [31:0]      in_inst,
    input  logic [31:0]      in_pc,
    output logic             in_ready,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_inst,
    output logic [31:0]      out_pc,
    output logic [4:0]       out_rs1_idx,
    output logic [4:0]       out_rs2_idx,
    output logic [4:0]       out_rd_idx,
    output logic [CNT_W-1:0] out_lat,
    output logic             out_illegal,
    output logic [31:0]      stall_cycles
);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;

    localparam logic [CNT_W-1:0] LD_L  = CNT_W'(LD_LAT);
    localparam logic [CNT_W-1:0] MUL_L = CNT_W'(MUL_LAT);
    localparam logic [CNT_W-1:0] ALU_L = CNT_W'(ALU_LAT);

`ifdef ID_SB_FWD_EN
    localparam logic [CNT_W-1:0] RDY_TH = CNT_W'(1);
`else
    localparam logic [CNT_W-1:0] RDY_TH = CNT_W'(0);
`endif

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    logic             id_valid;
    logic [31:0]      inst_p0;
    logic [31:0]      pc_p0;
    logic [CNT_W-1:0] cnt [32];

    logic             accept;
    logic             issue;
    logic [6:0]       opcode;
    logic             use_rs1;
    logic             use_rs2;
    logic             wr_rd;
    logic             illegal;
    logic [CNT_W-1:0] lat;
    logic [4:0]       rs1_idx;
    logic [4:0]       rs2_idx;
    logic [4:0]       rd_idx;
    logic             raw_hz;
    logic             waw_hz;

    assign opcode = inst_p0[6:0];

    always_comb begin
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        wr_rd   = 1'b0;
        illegal = 1'b0;
        case (opcode)
            OP_R:                begin use_rs1 = 1'b1; use_rs2 = 1'b1; wr_rd = 1'b1; end
            OP_S, OP_B:          begin use_rs1 = 1'b1; use_rs2 = 1'b1; end
            OP_I, OP_LD, OP_JALR: begin use_rs1 = 1'b1; wr_rd = 1'b1; end
            OP_JAL, OP_LUI, OP_AUIPC: wr_rd = 1'b1;
            default:             illegal = 1'b1;
        endcase
    end

    always_comb begin
        lat = ALU_L;
        if (opcode == OP_LD)
            lat = LD_L;
        else if (opcode == OP_R && inst_p0[31:25] == 7'h01)
            lat = MUL_L;
    end

    // Unused sources and non-writing destinations read as x0, which is never busy.
    assign rs1_idx = use_rs1 ? inst_p0[19:15] : 5'd0;
    assign rs2_idx = use_rs2 ? inst_p0[24:20] : 5'd0;
    assign rd_idx  = wr_rd   ? inst_p0[11:7]  : 5'd0;

    assign raw_hz = (cnt[rs1_idx] > RDY_TH) || (cnt[rs2_idx] > RDY_TH);
    assign waw_hz = (rd_idx != 5'd0) && (cnt[rd_idx] > lat);

    assign out_valid = id_valid && !raw_hz && !waw_hz;
    assign issue     = out_valid && out_ready;
    assign in_ready  = !id_valid || issue;
    assign accept    = in_valid && in_ready && !flush;

    assign out_inst    = inst_p0;
    assign out_pc      = pc_p0;
    assign out_rs1_idx = rs1_idx;
    assign out_rs2_idx = rs2_idx;
    assign out_rd_idx  = rd_idx;
    assign out_lat     = lat;
    assign out_illegal = illegal;

    // Stage p0: decode register control and stall accounting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_valid     <= 1'b0;
            stall_cycles <= 32'd0;
        end else begin
            if (flush)
                id_valid <= 1'b0;
            else if (accept)
                id_valid <= 1'b1;
            else if (issue)
                id_valid <= 1'b0;
            if (id_valid && !out_valid)
                stall_cycles <= sat_inc(stall_cycles);
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            inst_p0 <= in_inst;
            pc_p0   <= in_pc;
        end
    end

    // Busy table: an issuing writer's load wins over the free-running drain; flush never clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < 32; r++)
                cnt[r] <= '0;
        end else begin
            cnt[0] <= '0;
            for (int r = 1; r < 32; r++) begin
                if (issue && rd_idx == 5'(r))
                    cnt[r] <= lat;
                else if (cnt[r] != '0)
                    cnt[r] <= cnt[r] - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_decode_scoreboard.sv
// Directed bench for decode_scoreboard: hazards, WAW, x0, flush, out_ready backpressure and reset.
module tb_decode_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic        in_ready;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic [4:0]  out_rs1_idx;
    logic [4:0]  out_rs2_idx;
    logic [4:0]  out_rd_idx;
    logic [2:0]  out_lat;
    logic        out_illegal;
    logic [31:0] stall_cycles;

    int total = 0;
    int bad   = 0;
    int waited;
    logic [31:0] exp_stall;

`ifdef ID_SB_FWD_EN
    localparam int LD_STALL = 1;
`else
    localparam int LD_STALL = 2;
`endif

    localparam logic [31:0] LW5    = 32'h0000A283;
    localparam logic [31:0] ADD651 = 32'h00128333;
    localparam logic [31:0] MUL7   = 32'h022083B3;
    localparam logic [31:0] ADDI7  = 32'h00100393;
    localparam logic [31:0] ADD0   = 32'h00208033;
    localparam logic [31:0] ADD300 = 32'h000001B3;
    localparam logic [31:0] SUB655 = 32'h40528333;
    localparam logic [31:0] ADD850 = 32'h00028433;
    localparam logic [31:0] SW21   = 32'h0020A023;
    localparam logic [31:0] ILL    = 32'h0000007F;
    localparam logic [31:0] LUI9   = 32'h000004B7;

    decode_scoreboard dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_inst(in_inst), .in_pc(in_pc),
        .in_ready(in_ready), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_inst(out_inst), .out_pc(out_pc), .out_rs1_idx(out_rs1_idx),
        .out_rs2_idx(out_rs2_idx), .out_rd_idx(out_rd_idx), .out_lat(out_lat),
        .out_illegal(out_illegal), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic present(input logic [31:0] inst, input logic [31:0] pc);
        in_valid = 1'b1;
        in_inst  = inst;
        in_pc    = pc;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Leaves the caller at the negedge of the first cycle in which out_valid is high.
    task automatic wait_issue(output int n);
        n = 20;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) begin
                n = i;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_inst = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b1;
        exp_stall = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_stall", stall_cycles, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Load-use: LW x5 then ADD x6,x5,x1 back to back.
        present(LW5, 32'h100);
        @(negedge clk);
        chk("lw_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        present(ADD651, 32'h104);
        @(negedge clk);
        chk("lw_valid", {31'd0, out_valid}, 32'd1);
        chk("lw_rd", {27'd0, out_rd_idx}, 32'd5);
        chk("lw_rs1", {27'd0, out_rs1_idx}, 32'd1);
        chk("lw_rs2", {27'd0, out_rs2_idx}, 32'd0);
        chk("lw_lat", {29'd0, out_lat}, 32'd2);
        chk("lw_pc", out_pc, 32'h100);
        chk("lw_in_ready_issue", {31'd0, in_ready}, 32'd1);
        tick();
        wait_issue(waited);
        exp_stall = exp_stall + LD_STALL;
        chk("ldu_wait", waited, LD_STALL);
        chk("ldu_stall", stall_cycles, exp_stall);
        chk("ldu_inst", out_inst, ADD651);
        chk("ldu_rd", {27'd0, out_rd_idx}, 32'd6);
        chk("ldu_rs1", {27'd0, out_rs1_idx}, 32'd5);
        chk("ldu_rs2", {27'd0, out_rs2_idx}, 32'd1);
        tick();

        // WAW: MUL x7 then ADDI x7,x0,1.
        present(MUL7, 32'h200);
        tick();
        present(ADDI7, 32'h204);
        @(negedge clk);
        chk("mul_valid", {31'd0, out_valid}, 32'd1);
        chk("mul_lat", {29'd0, out_lat}, 32'd3);
        tick();
        wait_issue(waited);
        exp_stall = exp_stall + 2;
        chk("waw_wait", waited, 32'd2);
        chk("waw_stall", stall_cycles, exp_stall);
        chk("waw_rd", {27'd0, out_rd_idx}, 32'd7);
        chk("waw_rs1", {27'd0, out_rs1_idx}, 32'd0);
        chk("waw_lat", {29'd0, out_lat}, 32'd1);
        tick();
        @(negedge clk);
        chk("waw_cnt7", {29'd0, dut.cnt[7]}, 32'd1);
        chk("waw_idle", {31'd0, out_valid}, 32'd0);

        // x0 destination never marks a hazard.
        present(ADD0, 32'h300);
        tick();
        present(ADD300, 32'h304);
        @(negedge clk);
        chk("x0_valid", {31'd0, out_valid}, 32'd1);
        chk("x0_rd", {27'd0, out_rd_idx}, 32'd0);
        tick();
        @(negedge clk);
        chk("x0_next_valid", {31'd0, out_valid}, 32'd1);
        chk("x0_next_rd", {27'd0, out_rd_idx}, 32'd3);
        chk("x0_stall", stall_cycles, exp_stall);
        tick();

        // Field decode of store, illegal and LUI.
        present(SW21, 32'h400);
        tick();
        @(negedge clk);
        chk("sw_rd", {27'd0, out_rd_idx}, 32'd0);
        chk("sw_rs2", {27'd0, out_rs2_idx}, 32'd2);
        chk("sw_rs1", {27'd0, out_rs1_idx}, 32'd1);
        chk("sw_ill", {31'd0, out_illegal}, 32'd0);
        tick();
        present(ILL, 32'h404);
        tick();
        @(negedge clk);
        chk("ill_flag", {31'd0, out_illegal}, 32'd1);
        chk("ill_rd", {27'd0, out_rd_idx}, 32'd0);
        chk("ill_rs1", {27'd0, out_rs1_idx}, 32'd0);
        chk("ill_valid", {31'd0, out_valid}, 32'd1);
        tick();
        present(LUI9, 32'h408);
        tick();
        out_ready = 1'b0;
        present(ADD300, 32'h40C);
        @(negedge clk);
        chk("bp_valid", {31'd0, out_valid}, 32'd1);
        chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        present(SW21, 32'h410);
        tick();
        @(negedge clk);
        chk("bp_inst", out_inst, LUI9);
        chk("bp_pc", out_pc, 32'h408);
        chk("bp_rd", {27'd0, out_rd_idx}, 32'd9);
        chk("bp_stall", stall_cycles, exp_stall);
        out_ready = 1'b1;
        tick();

        // Flush drops the held SUB; the busy counter keeps draining.
        present(LW5, 32'h500);
        tick();
        present(SUB655, 32'h504);
        tick();
        flush = 1'b1;
        @(negedge clk);
        chk("fl_sub_stalled", {31'd0, out_valid}, 32'd0);
        chk("fl_sub_inst", out_inst, SUB655);
        tick();
        flush = 1'b0;
        exp_stall = exp_stall + 1;
        @(negedge clk);
        chk("fl_dropped", {31'd0, out_valid}, 32'd0);
        chk("fl_in_ready", {31'd0, in_ready}, 32'd1);
        chk("fl_cnt5", {29'd0, dut.cnt[5]}, 32'd1);
        chk("fl_stall", stall_cycles, exp_stall);
        present(ADD850, 32'h508);
        tick();
        wait_issue(waited);
        chk("fl_add_wait", waited, 32'd0);
        chk("fl_add_rd", {27'd0, out_rd_idx}, 32'd8);
        tick();

        // Reset in the middle of a load-use stall.
        present(LW5, 32'h600);
        tick();
        present(ADD651, 32'h604);
        tick();
        @(negedge clk);
        chk("rs_stalled", {31'd0, out_valid}, 32'd0);
        chk("rs_cnt5", {29'd0, dut.cnt[5]}, 32'd2);
        rst = 1'b1;
        #1;
        chk("rs_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rs_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rs_stall", stall_cycles, 32'd0);
        tick();
        rst = 1'b0;
        present(ADD651, 32'h700);
        tick();
        @(negedge clk);
        chk("rs_add_valid", {31'd0, out_valid}, 32'd1);
        chk("rs_add_stall", stall_cycles, 32'd0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
